multdiv_controller: RTL and testbench

Sequencing controller plus iterative engine for the execute stage's multiply (`mul`) and divide (`div`) instructions. The block accepts one operation from X and stalls the front of the pipeline while it iterates. It then presents a single-cycle result, with destination register and exception status, for X to forward into the X/M latch. The block replaces the single-cycle ALU path for `isMul`/`isDiv`, which is unsuitable for 32-bit signed multiply and divide.

---
 rtl/multdiv_controller_if.sv | 28 ++
 rtl/multdiv_controller.sv | 143 ++++++++++++++
 tb/tb_multdiv_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/multdiv_controller_if.sv
// Handshake and data bundle between the execute stage (master) and the
// iterative multiply/divide controller (slave).
interface multdiv_controller_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_mul;
    logic             is_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       rd_in;
    logic             stall;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             exception;

    modport master (
        output start, is_mul, is_div, op_a, op_b, rd_in,
        input  stall, busy, result_valid, result, rd_out, exception
    );

    modport slave (
        input  start, is_mul, is_div, op_a, op_b, rd_in,
        output stall, busy, result_valid, result, rd_out, exception
    );
endinterface

// File: rtl/multdiv_controller.sv
// Iterative signed multiply/divide engine for the execute stage: shift-add
// multiply and restoring divide on magnitudes, one bit per cycle, sign fixed up at the end.
module multdiv_controller #(
    parameter int          WIDTH   = 32,
    parameter logic [4:0]  RSTATUS = 5'd30
) (
    input  logic                clock,
    input  logic                resetn,
    multdiv_controller_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, next_state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sign_a, sign_b;
    logic               op_is_mul;
    logic [4:0]         rd_lat;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         rd_out_q;
    logic               exception_q;

    logic               accept;
    logic               div_zero;
    logic               stall_c;
    logic               neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
    logic [2*WIDTH-1:0] acc_step, prod_signed;
    logic [WIDTH-1:0]   quot_signed;
    logic               mul_ovf;

    assign abs_a    = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    assign abs_b    = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
    assign div_zero = bus.is_div && (bus.op_b == '0);
    assign neg      = sign_a ^ sign_b;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        stall_c    = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.start && (bus.is_mul ^ bus.is_div);
                if (accept) begin
                    stall_c    = 1'b1;
                    next_state = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                stall_c = 1'b1;
                if (count == LAST) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_b};
        if (op_is_mul)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (!rem_diff[WIDTH])
            acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        prod_signed = neg ? -acc_step : acc_step;
        quot_signed = neg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        mul_ovf     = (prod_signed[2*WIDTH-1:WIDTH-1] != '0) &&
                      (prod_signed[2*WIDTH-1:WIDTH-1] != '1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count       <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            op_is_mul   <= 1'b0;
            rd_lat      <= '0;
            acc         <= '0;
            result_q    <= '0;
            rd_out_q    <= '0;
            exception_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag_a     <= abs_a;
                        mag_b     <= abs_b;
                        sign_a    <= bus.op_a[WIDTH-1];
                        sign_b    <= bus.op_b[WIDTH-1];
                        op_is_mul <= bus.is_mul;
                        rd_lat    <= bus.rd_in;
                        count     <= '0;
                        acc       <= {{WIDTH{1'b0}}, (bus.is_mul ? abs_b : abs_a)};
                        if (div_zero) begin
                            result_q    <= WIDTH'(5);
                            rd_out_q    <= RSTATUS;
                            exception_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        if (op_is_mul && mul_ovf) begin
                            result_q    <= WIDTH'(4);
                            rd_out_q    <= RSTATUS;
                            exception_q <= 1'b1;
                        end else begin
                            result_q    <= op_is_mul ? prod_signed[WIDTH-1:0] : quot_signed;
                            rd_out_q    <= rd_lat;
                            exception_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall        = stall_c;
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;
    assign bus.exception    = exception_q;
endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller: a vector table of operations with
// hand-computed results and latencies, plus sequences for illegal, busy and reset cases.
module tb_multdiv_controller;
    logic clock;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    multdiv_controller_if #(.WIDTH(32)) bus ();

    multdiv_controller #(.WIDTH(32), .RSTATUS(5'd30)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        is_mul;
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_exc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Runs one operation; optionally pulses a second start at cycle inject_cyc
    task automatic apply_stimulus(input vec_t v, input int inject_cyc, input string tag);
        int lat = 0;
        int stall_hi = 0;
        int busy_hi = 0;
        @(negedge clock);
        bus.start  = 1'b1;
        bus.is_mul = v.is_mul;
        bus.is_div = v.is_div;
        bus.op_a   = v.a;
        bus.op_b   = v.b;
        bus.rd_in  = v.rd;
        #1;
        check_output({tag, " stall_c0"}, 32'(bus.stall), 32'd1);
        check_output({tag, " busy_c0"}, 32'(bus.busy), 32'd0);
        @(posedge clock); #1;
        bus.start  = 1'b0;
        bus.is_mul = ~v.is_mul;
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (c == inject_cyc) begin
                bus.start  = 1'b1;
                bus.is_mul = 1'b1;
                bus.is_div = 1'b0;
                bus.op_a   = 32'd3;
                bus.op_b   = 32'd5;
                bus.rd_in  = 5'd15;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.result_valid) begin
                lat = c;
                break;
            end
            if (bus.stall) stall_hi++;
            if (bus.busy)  busy_hi++;
            @(posedge clock); #1;
        end
        check_output({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check_output({tag, " stall_cycles"}, 32'(stall_hi), 32'(v.exp_lat - 1));
        check_output({tag, " busy_cycles"}, 32'(busy_hi), 32'(v.exp_lat - 1));
        if (lat != 0) begin
            check_output({tag, " result"}, bus.result, v.exp_res);
            check_output({tag, " rd_out"}, 32'(bus.rd_out), 32'(v.exp_rd));
            check_output({tag, " exception"}, 32'(bus.exception), 32'(v.exp_exc));
            check_output({tag, " stall_done"}, 32'(bus.stall), 32'd0);
            check_output({tag, " busy_done"}, 32'(bus.busy), 32'd1);
            @(posedge clock); #1;
            bus.start = 1'b0;
            check_output({tag, " valid_after"}, 32'(bus.result_valid), 32'd0);
            check_output({tag, " busy_after"}, 32'(bus.busy), 32'd0);
            check_output({tag, " result_held"}, bus.result, v.exp_res);
        end
    endtask

    initial begin
        int extra;
        resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.is_mul = 1'b0;
        bus.is_div = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;

        vecs.push_back('{1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 5'd3,  32'hFFFFFFD6, 5'd3,  1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00010000, 5'd4,  32'd4,        5'd30, 1'b1, 33});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd5,  32'd4,        5'd30, 1'b1, 33});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        5'd9,  32'hFFFFFFF2, 5'd9,  1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, 5'd6,  1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'd12,       32'd0,        5'd7,  32'd5,        5'd30, 1'b1, 1});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'd1,        5'd1,  1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'd1,        5'd2,  32'h80000000, 5'd2,  1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 5'd8,  32'hFFFFFFF2, 5'd8,  1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'd7,        32'd100,      5'd10, 32'd0,        5'd10, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'd0,        5'd19, 32'd5,        5'd30, 1'b1, 1});
        vecs.push_back('{1'b1, 1'b0, 32'h7FFFFFFF, 32'd0,        5'd11, 32'd0,        5'd11, 1'b0, 33});
        vecs.push_back('{1'b1, 1'b0, 32'd46341,    32'd46341,    5'd20, 32'd4,        5'd30, 1'b1, 33});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFF4AFC, 32'd46340,    5'd12, 32'h800157F0, 5'd12, 1'b0, 33});
        vecs.push_back('{1'b0, 1'b1, 32'h80000000, 32'd2,        5'd13, 32'hC0000000, 5'd13, 1'b0, 33});

        #12;
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset valid", 32'(bus.result_valid), 32'd0);
        check_output("reset result", bus.result, 32'd0);
        check_output("reset rd_out", 32'(bus.rd_out), 32'd0);
        check_output("reset exception", 32'(bus.exception), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        foreach (vecs[i]) apply_stimulus(vecs[i], 0, $sformatf("vec%0d", i));

        // Both or neither op bit set: request must be ignored
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            bus.start  = 1'b1;
            bus.is_mul = (k == 0);
            bus.is_div = (k == 0);
            #1;
            check_output($sformatf("illegal%0d stall", k), 32'(bus.stall), 32'd0);
            @(posedge clock); #1;
            check_output($sformatf("illegal%0d busy", k), 32'(bus.busy), 32'd0);
            check_output($sformatf("illegal%0d valid", k), 32'(bus.result_valid), 32'd0);
            bus.start = 1'b0;
        end

        // Start pulsed during RUN and during DONE must not start a second op
        for (int k = 0; k < 2; k++) begin
            apply_stimulus('{1'b1, 1'b0, 32'd2, 32'd2, 5'd14, 32'd4, 5'd14, 1'b0, 33},
                           (k == 0) ? 5 : 33, $sformatf("busyreq%0d", k));
            extra = 0;
            for (int c = 0; c < 40; c++) begin
                if (bus.result_valid) extra++;
                @(posedge clock); #1;
            end
            check_output($sformatf("busyreq%0d extra_valid", k), 32'(extra), 32'd0);
        end

        // Reset in cycle 10 of a multiply
        @(negedge clock);
        bus.start  = 1'b1;
        bus.is_mul = 1'b1;
        bus.is_div = 1'b0;
        bus.op_a   = 32'h1234;
        bus.op_b   = 32'h5678;
        bus.rd_in  = 5'd16;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check_output("midreset stall", 32'(bus.stall), 32'd0);
        check_output("midreset busy", 32'(bus.busy), 32'd0);
        check_output("midreset valid", 32'(bus.result_valid), 32'd0);
        check_output("midreset result", bus.result, 32'd0);
        check_output("midreset rd_out", 32'(bus.rd_out), 32'd0);
        check_output("midreset exception", 32'(bus.exception), 32'd0);
        @(posedge clock); #1;
        check_output("midreset busy_hold", 32'(bus.busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        apply_stimulus('{1'b1, 1'b0, 32'd9, 32'd9, 5'd17, 32'd81, 5'd17, 1'b0, 33}, 0, "postreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
